// File: rtl/i2s_audio_tx.sv
// ---------------------------------------------------------------------------
// i2s_audio_tx
//   Stereo I2S transmitter for the Pmod I2S DAC. One free-running frame
//   counter produces every timing signal: MCLK = clk/4, SCK = clk/16, and
//   LRCK = clk/2^FRAME_LOG2. The left and right samples are copied into
//   shadow registers once per frame, on the counter wrap. Each sample is
//   then shifted out MSB first, one SCK after each LRCK edge, in standard
//   I2S framing.
//
// Ports
//   clk            system clock (100 MHz)
//   rst            asynchronous reset, active low
//   audio_in_left  left sample, two's complement, sampled only at the wrap
//   audio_in_right right sample, two's complement, sampled only at the wrap
//   mute           when high at the wrap, zeros are latched for both channels
//   audio_mclk     DAC master clock, cnt[1]
//   audio_lrck     word select (0 = left, 1 = right), cnt[FRAME_LOG2-1]
//   audio_sck      serial bit clock, cnt[3]
//   audio_sdin     serial data; changes only on SCK falling edges
//   frame_start    high for one cycle, while cnt == 0 after a latch
//   cur_left       left shadow register (the sample now being sent)
// ---------------------------------------------------------------------------
module i2s_audio_tx #(
    parameter int SAMPLE_W   = 16,
    parameter int FRAME_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] audio_in_left,
    input  logic [SAMPLE_W-1:0] audio_in_right,
    input  logic                mute,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin,
    output logic                frame_start,
    output logic [SAMPLE_W-1:0] cur_left
);

    // Each half frame holds 2^(FRAME_LOG2-5) slots of 16 clk each.
    localparam int SLOT_W = FRAME_LOG2 - 5;

    logic [FRAME_LOG2-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0]   shl_q, shr_q;
    logic                  sdin_q, sdin_d;
    logic                  fs_q;

    logic                  wrap;
    logic                  bit_tick;
    logic [SLOT_W-1:0]     slot_d;
    logic                  half_d;
    logic [SAMPLE_W-1:0]   word;
    logic [SAMPLE_W-1:0]   mask;
    int                    slot_i;

    assign cnt_d    = cnt_q + FRAME_LOG2'(1);
    assign wrap     = &cnt_q;
    // The next edge moves cnt[3:0] to 0000, which is the SCK falling edge.
    assign bit_tick = &cnt_q[3:0];
    assign slot_d   = cnt_d[FRAME_LOG2-2:4];
    assign half_d   = cnt_d[FRAME_LOG2-1];

    // The serial bit is chosen from the slot that the counter enters on the
    // next edge. Slot 0 is the one-SCK I2S delay. Slots past the sample
    // width are padded with zeros.
    always_comb begin
        word   = half_d ? shr_q : shl_q;
        slot_i = int'(slot_d);
        mask   = '0;
        sdin_d = 1'b0;
        if (slot_i >= 1 && slot_i <= SAMPLE_W) begin
            mask   = SAMPLE_W'(1) << (SAMPLE_W - slot_i);
            sdin_d = |(word & mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            shl_q  <= '0;
            shr_q  <= '0;
            sdin_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fs_q  <= wrap;
            if (wrap) begin
                shl_q <= mute ? '0 : audio_in_left;
                shr_q <= mute ? '0 : audio_in_right;
            end
            if (bit_tick) begin
                sdin_q <= sdin_d;
            end
        end
    end

    assign audio_mclk  = cnt_q[1];
    assign audio_sck   = cnt_q[3];
    assign audio_lrck  = cnt_q[FRAME_LOG2-1];
    assign audio_sdin  = sdin_q;
    assign frame_start = fs_q;
    assign cur_left    = shl_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_audio_tx
//   Self-checking bench for i2s_audio_tx. A table of frame vectors drives
//   the inputs. Each vector may include a mid-frame disturbance window that
//   must not reach the DAC. When a vector's latch cycle is driven, its index
//   is pushed to a scoreboard queue. A monitor pops the entry at every frame
//   start and checks the whole transmitted frame against it.
// ---------------------------------------------------------------------------
module tb_i2s_audio_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_l = 16'h0;
    logic [15:0] in_r = 16'h0;
    logic        mute = 1'b0;
    logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start;
    logic [15:0] cur_left;

    i2s_audio_tx #(.SAMPLE_W(16), .FRAME_LOG2(10)) dut (
        .clk           (clk),
        .rst           (rst),
        .audio_in_left (in_l),
        .audio_in_right(in_r),
        .mute          (mute),
        .audio_mclk    (audio_mclk),
        .audio_lrck    (audio_lrck),
        .audio_sck     (audio_sck),
        .audio_sdin    (audio_sdin),
        .frame_start   (frame_start),
        .cur_left      (cur_left)
    );

    always #5 clk = ~clk;

    // Frame position seen by the bench: clk edges counted since reset release.
    logic [9:0] tcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) tcnt <= 10'd0;
        else      tcnt <= tcnt + 10'd1;
    end

    typedef struct {
        logic [15:0] l, r;     // inputs held outside the disturbance window
        logic        m;
        int          g_from;   // disturbance window [g_from, g_to)
        int          g_to;
        logic [15:0] gl, gr;   // inputs inside the window
        logic        gm;
        logic [15:0] el, er;   // samples expected in the next frame
    } vec_t;

    localparam int NV    = 13;
    localparam int PRE_N = 11;
    vec_t vt[NV];

    int n_cmp = 0;
    int n_bad = 0;
    int sb[$];
    bit done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        bit          active;
        bit          first;
        logic [15:0] exp_l, exp_r;
        logic [63:0] cap;
        logic        prev_sdin;
        int          clk_err, sh_err, gl_err, vi, idx;
        active = 0; first = 0; exp_l = '0; exp_r = '0; cap = '0; prev_sdin = 0;
        clk_err = 0; sh_err = 0; gl_err = 0; vi = -1;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!rst) begin
                active = 0;
                sb.delete();
            end else begin
                if (!active) begin
                    active = 1; first = 1; exp_l = '0; exp_r = '0; vi = -1;
                    clk_err = 0; sh_err = 0; gl_err = 0; prev_sdin = 1'b0; cap = '0;
                    chk("first_frame_cur_left", 64'(cur_left), 64'h0);
                end else if (tcnt == 10'd0) begin
                    first = 0;
                    clk_err = 0; sh_err = 0; gl_err = 0; cap = '0;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 64'(sb.size()), 64'd1);
                        exp_l = '0; exp_r = '0; vi = -1;
                    end else begin
                        vi = sb.pop_front();
                        exp_l = vt[vi].el;
                        exp_r = vt[vi].er;
                    end
                    chk($sformatf("frame_start_v%0d", vi), 64'(frame_start), 64'd1);
                    chk($sformatf("cur_left_latch_v%0d", vi), 64'(cur_left), 64'(exp_l));
                end
                if (audio_mclk !== tcnt[1] || audio_sck !== tcnt[3] ||
                    audio_lrck !== tcnt[9] ||
                    frame_start !== (tcnt == 10'd0 && !first))
                    clk_err++;
                if (cur_left !== exp_l) sh_err++;
                if (audio_sdin !== prev_sdin && tcnt[3:0] != 4'd0) gl_err++;
                prev_sdin = audio_sdin;
                if (tcnt[3:0] == 4'd8) begin
                    idx = 63 - int'(tcnt[9:4]);
                    cap[idx] = audio_sdin;
                end
                if (tcnt == 10'd1023) begin
                    chk($sformatf("sdin_frame_v%0d", vi), cap, frame_bits(exp_l, exp_r));
                    chk($sformatf("clock_errs_v%0d", vi), 64'(clk_err), 64'd0);
                    chk($sformatf("shadow_errs_v%0d", vi), 64'(sh_err), 64'd0);
                    chk($sformatf("sdin_glitch_v%0d", vi), 64'(gl_err), 64'd0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input int i);
        int c;
        int guard;
        guard = 0;
        do begin
            step();
            c = int'(tcnt);
            guard++;
            if (c >= vt[i].g_from && c < vt[i].g_to) begin
                in_l = vt[i].gl; in_r = vt[i].gr; mute = vt[i].gm;
            end else begin
                in_l = vt[i].l;  in_r = vt[i].r;  mute = vt[i].m;
            end
        end while (c != 1023 && guard < 2100);
        chk($sformatf("vec_reach_latch_v%0d", i), 64'(c), 64'd1023);
        sb.push_back(i);
    endtask

    task automatic wait_cnt(input int target, input string nm);
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (int'(tcnt) != target && guard < 2100);
        chk(nm, 64'(tcnt), 64'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          l        r        m     from  to    gl       gr       gm    el       er
        vt[0]  = '{16'hA000, 16'h6000, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'hA000, 16'h6000};
        vt[1]  = '{16'hA000, 16'h6000, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'hA000, 16'h6000};
        vt[2]  = '{16'hF000, 16'h0F0F, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'hF000, 16'h0F0F};
        vt[3]  = '{16'h1000, 16'h0F0F, 1'b0, 0,    300,  16'hF000, 16'h0F0F, 1'b0, 16'h1000, 16'h0F0F};
        vt[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'hFFFF, 16'hFFFF};
        vt[5]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1023, 1024, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'h0000};
        vt[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 500,  501,  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF};
        vt[7]  = '{16'h0000, 16'h0000, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'h0000, 16'h0000};
        vt[8]  = '{16'h8001, 16'h7FFE, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'h8001, 16'h7FFE};
        vt[9]  = '{16'hAAAA, 16'h5555, 1'b0, 100,  900,  16'h1234, 16'h4321, 1'b1, 16'hAAAA, 16'h5555};
        vt[10] = '{16'hC3A5, 16'h5A5A, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'hC3A5, 16'h5A5A};
        vt[11] = '{16'h1234, 16'hABCD, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'h1234, 16'hABCD};
        vt[12] = '{16'h0000, 16'h0000, 1'b0, 0,    0,    16'h0,    16'h0,    1'b0, 16'h0000, 16'h0000};

        in_l = vt[0].l; in_r = vt[0].r; mute = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", 64'({audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start, cur_left}), 64'h0);
        rst = 1'b1;

        for (int i = 0; i < PRE_N; i++) run_vec(i);

        // Reset in the middle of the right half, while the outputs are non-zero.
        wait_cnt(600, "reach_cnt_600");
        chk("pre_reset_lrck", 64'(audio_lrck), 64'd1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start, cur_left}), 64'h0);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_hold_outputs", 64'({audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start, cur_left}), 64'h0);
        rst = 1'b1;

        for (int i = PRE_N; i < NV; i++) run_vec(i);

        wait_cnt(1023, "final_frame_end");
        @(negedge clk);
        #1;
        done = 1'b1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- Transmitter end of the audio sample path. Takes the parallel 16-bit left/right samples produced by the note/noise/AM generators.
- Serializes them to the Pmod I2S stereo DAC in standard I2S format.
- Generates MCLK, LRCK and SCK from the 100 MHz system clock.
- Samples are latched once per frame, so generator glitches mid-frame never reach the DAC.

Parameters:
- SAMPLE_W, 16, sample width in bits; must be ≤ 31.
- FRAME_LOG2, 10, log2 of clk cycles per LRCK period (1024 → 97.656 kHz at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- audio_in_left  in  SAMPLE_W  left sample, two's-complement
- audio_in_right  in  SAMPLE_W  right sample, two's-complement
- mute  in  1  force zero samples from next frame
- audio_mclk  out  1  DAC master clock, clk/4
- audio_lrck  out  1  word select; 0 = left, 1 = right
- audio_sck  out  1  serial bit clock, clk/16
- audio_sdin  out  1  serial data, MSB first
- frame_start  out  1  one-cycle pulse on the cycle samples are latched
- cur_left  out  SAMPLE_W  currently transmitting left sample (shadow register)

Behaviour:
- Free-running counter cnt[FRAME_LOG2-1:0] increments every clk and wraps 1023→0. All timing derives from cnt; there are no other dividers.
- audio_mclk = cnt[1], audio_sck = cnt[3], audio_lrck = cnt[9]. All are registered/derived from registered cnt, so they are glitch-free.
- This gives 64 SCK periods per frame and 32 slots per channel half.
- Slot index s = cnt[8:4] (0..31) within each half; the half is selected by cnt[9].
- Sample latch: on the edge where cnt goes 1023→0, the shadow registers load.
  - Normal: shL ← audio_in_left, shR ← audio_in_right.
  - If mute = 1 on that edge, both shadow registers load 0.
  - frame_start = 1 exactly while cnt == 0.
  - Inputs are ignored on all other cycles.
- I2S framing: data is delayed one SCK after each LRCK edge and changes only on SCK falling edges.
  - The DAC samples on rising edges.
  - audio_sdin is a register updated only on the edge where cnt[3:0] becomes 0000.
  - Its value is the bit for slot s of the new cnt:
    - s = 0: 0
    - s = 1..SAMPLE_W: bit (SAMPLE_W - s) of shL (cnt[9] = 0) or shR (cnt[9] = 1)
    - s > SAMPLE_W: 0
  - The left half reads shL latched at that frame start. The right half reads the same frame's shR.
- Latency: audio_in_left bit15 appears on audio_sdin 16 clk after the latch edge (cnt 16..31). Right bit15 appears at cnt 528..543.
- Sample width rule: samples are sent verbatim with no sign extension or scaling. Volume is the generators' job.
- Reset (rst = 0, asynchronous):
  - cnt = 0, shL = shR = 0.
  - audio_sdin = 0, frame_start = 0.
  - audio_mclk / audio_lrck / audio_sck = 0.
- After reset release:
  - The first frame (cnt 0..1023) transmits zeros.
  - The first real latch is at the first 1023→0 wrap, with frame_start at 1024 clk after release.
- Reset mid-frame truncates the frame immediately; no partial-frame recovery is attempted.
- mute asserted mid-frame does not affect the current frame; it takes effect at the next latch.
- Input changes mid-frame have no effect until the next latch.
- cur_left = shL.

Test Plan:
- Clock check: after reset, measure periods → audio_mclk 4 clk, audio_sck 16 clk, audio_lrck 1024 clk with 50% duty; lrck low for cnt 0..511.
- Left=16'hA000, right=16'h6000 held constant → after the second frame_start:
  - sdin over left slots 1..16 = 1010 0000 0000 0000.
  - Right slots 1..16 = 0110 0000 0000 0000.
  - Slots 0 and 17..31 are 0; sdin never changes except at cnt[3:0] = 0.
- Change left from 16'hF000 to 16'h1000 at cnt = 300 → current frame still sends F000; next frame sends 1000; cur_left updates only on the frame_start cycle.
- mute = 1 pulsed only at cnt = 1023 with left = 16'hFFFF → the following frame is all zeros. A mute pulse at cnt = 500 has no effect.
- Assert rst at cnt = 600 for 3 clk → all outputs 0 immediately (asynchronous). After release, the first frame is zero and frame_start occurs 1024 clk later.
- Inputs = 16'h0000 → audio_sdin stays 0 for a full frame while clocks keep toggling.
